// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter in front of a word-wide data memory, with byte-lane steering and load extension.
// Optional feature: define DMEM_ARB_MISALIGN_CHK_EN to flag misaligned or illegal-size accesses as errors.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_we,
    input  logic [1:0]            m0_size,
    input  logic                  m0_unsigned,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rsp_valid,
    input  logic                  m0_rsp_ready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rsp_err,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_we,
    input  logic [1:0]            m1_size,
    input  logic                  m1_unsigned,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rsp_valid,
    input  logic                  m1_rsp_ready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rsp_err,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [2:0]            mem_op_read,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [31:0] ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << ADDR_WIDTH) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // size 2'b11 behaves as a word whenever it is not flagged as an error
    function automatic logic [1:0] eff_size(input logic [1:0] s);
        return (s == 2'b11) ? 2'b10 : s;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] s, input logic [1:0] a);
        case (eff_size(s))
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] s, input logic [31:0] d);
        case (eff_size(s))
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] s, input logic u,
                                             input logic [1:0] a, input logic [31:0] w);
        logic [31:0] sh;
        case (eff_size(s))
            2'b00: begin
                sh = w >> {a, 3'b000};
                return u ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = w >> {a[1], 4'b0000};
                return u ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return w;
        endcase
    endfunction

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    function automatic logic misalign(input logic [1:0] s, input logic [1:0] a);
        return (s == 2'b11) || ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a != 2'b00));
    endfunction
`endif

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [31:0]     addr_q, wdata_q;
    logic            grant, winner, acc_err, own_rsp_ready;
    logic [31:0]     word_addr;

    assign word_addr     = {2'b00, addr_q[31:2]} & ADDR_MASK;
    assign own_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    assign acc_err = misalign(size_q, addr_q[1:0]);
`else
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        rsp_err_d    = rsp_err_q;
        grant        = 1'b0;
        winner       = 1'b0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        mem_addr     = 32'd0;
        mem_wdata    = '0;
        case (state_q)
            S_IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    grant        = 1'b1;
                    // on a tie the port that did not win last time goes first
                    winner       = (m0_req_valid && m1_req_valid) ? ~last_grant_q : m1_req_valid;
                    m0_req_ready = ~winner;
                    m1_req_ready = winner;
                    last_grant_d = winner;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_addr  = word_addr;
                mem_wdata = lane_wdata(size_q, wdata_q);
                if (!acc_err) begin
                    mem_we = we_q;
                    mem_be = lane_be(size_q, addr_q[1:0]);
                end
                rdata_d   = (we_q || acc_err) ? 32'd0
                          : load_ext(size_q, uns_q, addr_q[1:0], mem_rdata);
                rsp_err_d = acc_err;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (own_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rdata_q      <= 32'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            rsp_err_q    <= rsp_err_d;
            if (grant) owner_q <= winner;
        end
    end

    // Request fields are pure data; they are only consumed after a grant reloads them.
    always_ff @(posedge clk) begin
        if (grant) begin
            we_q    <= winner ? m1_we       : m0_we;
            size_q  <= winner ? m1_size     : m0_size;
            uns_q   <= winner ? m1_unsigned : m0_unsigned;
            addr_q  <= winner ? m1_addr     : m0_addr;
            wdata_q <= winner ? m1_wdata    : m0_wdata;
        end
    end

    assign mem_op_read  = 3'b010;
    assign m0_rsp_valid = (state_q == S_RESP) && !owner_q;
    assign m1_rsp_valid = (state_q == S_RESP) &&  owner_q;
    assign m0_rdata     = owner_q ? 32'd0 : rdata_q;
    assign m1_rdata     = owner_q ? rdata_q : 32'd0;
    assign m0_rsp_err   = rsp_err_q & ~owner_q;
    assign m1_rsp_err   = rsp_err_q &  owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a small behavioural word memory behind the memory port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_we, m0_unsigned, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_we, m1_unsigned, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [2:0]  mem_op_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [3:0]  last_be;
    logic [31:0] last_addr, last_wdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we),
        .m0_size(m0_size), .m0_unsigned(m0_unsigned), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata),
        .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we),
        .m1_size(m1_size), .m1_unsigned(m1_unsigned), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata),
        .m1_rsp_err(m1_rsp_err),
        .mem_we(mem_we), .mem_be(mem_be), .mem_op_read(mem_op_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[5:0]][8*i +: 8] = mem_wdata[8*i +: 8];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            last_be    = mem_be;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m0_rsp_valid && m0_rsp_ready) begin
            if (q0.size() == 0) check("m0_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("m0_rdata", m0_rdata, e0.rdata);
                check("m0_err", {31'd0, m0_rsp_err}, {31'd0, e0.err});
            end
        end
        if (rst_n && m1_rsp_valid && m1_rsp_ready) begin
            if (q1.size() == 0) check("m1_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("m1_rdata", m1_rdata, e1.rdata);
                check("m1_err", {31'd0, m1_rsp_err}, {31'd0, e1.err});
            end
        end
    end

    task automatic drive(input int p, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            m0_we = we; m0_size = sz; m0_unsigned = uns; m0_addr = a; m0_wdata = wd; m0_req_valid = 1'b1;
        end else begin
            m1_we = we; m1_size = sz; m1_unsigned = uns; m1_addr = a; m1_wdata = wd; m1_req_valid = 1'b1;
        end
    endtask

    task automatic push(input int p, input logic [31:0] rd, input logic er);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic wait_ready(input int p, input string nm);
        int n;
        n = 0;
        while (!((p == 0) ? m0_req_ready : m1_req_ready) && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        check(nm, {31'd0, (p == 0) ? m0_req_ready : m1_req_ready}, 32'd1);
    endtask

    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic er);
        @(negedge clk);
        drive(p, we, sz, uns, a, wd);
        #1;
        wait_ready(p, "req_ready");
        push(p, rd, er);
        @(posedge clk); #1;
        if (p == 0) m0_req_valid = 1'b0;
        else        m1_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        check({nm, "_pending"}, q0.size() + q1.size(), 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int n;
        rst_n = 1'b0;
        m0_req_valid = 0; m0_we = 0; m0_size = 0; m0_unsigned = 0; m0_addr = 0; m0_wdata = 0;
        m1_req_valid = 0; m1_we = 0; m1_size = 0; m1_unsigned = 0; m1_addr = 0; m1_wdata = 0;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {26'd0, m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid,
                          m0_rsp_err, m1_rsp_err}, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        check("rst_mem", {27'd0, mem_we, mem_be} | mem_addr | mem_wdata, 32'd0);
        check("mem_op_read", {29'd0, mem_op_read}, 32'd2);
        @(negedge clk) rst_n = 1'b1;

        // word store then load
        w0 = we_cnt;
        do_req(0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        wait_done("sw");
        check("sw_we_cycles", we_cnt - w0, 32'd1);
        check("sw_be", {28'd0, last_be}, 32'hF);
        check("sw_addr", last_addr, 32'd4);
        check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        wait_done("lw");

        // signed and unsigned byte loads
        mem[4] = 32'h0000_8000;
        do_req(1, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'd0, 32'hFFFF_FF80, 1'b0);
        wait_done("lb");
        do_req(1, 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'd0, 32'h0000_0080, 1'b0);
        wait_done("lbu");

        // upper halfword store then signed load
        mem[4] = 32'h1122_3344;
        do_req(0, 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_ABCD, 32'd0, 1'b0);
        wait_done("sh");
        check("sh_be", {28'd0, last_be}, 32'hC);
        check("sh_wdata", last_wdata, 32'hABCD_ABCD);
        check("sh_word", mem[4], 32'hABCD_3344);
        do_req(0, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0, 32'hFFFF_ABCD, 1'b0);
        wait_done("lh");

        // both ports requesting continuously from reset
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
        drive(1, 1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'd0);
        #1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (!(m0_req_ready || m1_req_ready) && n < 30) begin
                @(negedge clk); #1;
                n++;
            end
            check("rr_grant", {30'd0, m1_req_ready, m0_req_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
            if (g % 2 == 0) push(0, 32'hABCD_3344, 1'b0);
            else            push(1, 32'h0000_0044, 1'b0);
            @(posedge clk); #1;
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        wait_done("rr");

        // response back-pressure on port 0 while port 1 waits
        m0_rsp_ready = 1'b0;
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'hABCD_3344, 1'b0);
        drive(1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
        n = 0;
        while (!m0_rsp_valid && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", {31'd0, m0_rsp_valid}, 32'd1);
            check("hold_rdata", m0_rdata, 32'hABCD_3344);
            check("hold_m1_ready", {31'd0, m1_req_ready}, 32'd0);
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        m0_rsp_ready = 1'b1;
        @(negedge clk); #1;
        wait_ready(1, "hold_m1_grant");
        push(1, 32'hABCD_3344, 1'b0);
        @(posedge clk); #1;
        m1_req_valid = 1'b0;
        wait_done("hold");

        // misaligned word load
        w0 = we_cnt;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b1);
`else
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'd0, 32'hABCD_3344, 1'b0);
`endif
        wait_done("lw_13");
        check("lw_13_no_write", we_cnt - w0, 32'd0);

        // reset falling during the ACCESS cycle of a store
        mem[8] = 32'hCAFE_F00D;
        @(negedge clk);
        drive(0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1234_5678);
        #1;
        wait_ready(0, "rst_sw_ready");
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        check("rst_sw_access_we", {31'd0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_abort_mem", {27'd0, mem_we, mem_be} | mem_addr | mem_wdata, 32'd0);
        check("rst_abort_rsp", {30'd0, m0_rsp_valid, m0_rsp_err} | m0_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_abort_word", mem[8], 32'hCAFE_F00D);
        rst_n = 1'b1;
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 1'b0);
        wait_done("rst_lw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
